// File: rtl/tetris_move_sequencer_if.sv
// Command and datapath bundle between the move sequencer (master) and the game environment (slave).
interface tetris_move_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic [1:0]       cmd_code;
    logic             cmd_ready;
    logic             act_valid;
    logic [2:0]       action;
    logic [WIDTH-1:0] row_addr;
    logic             act_done;
    logic             is_move;
    logic             row_full;
    logic             spawn_blocked;
    logic [WIDTH-1:0] lines_cleared;
    logic             busy;
    logic             game_over;

    modport master (
        input  cmd_valid, cmd_code, act_done, is_move, row_full, spawn_blocked,
        output cmd_ready, act_valid, action, row_addr, lines_cleared, busy, game_over
    );

    modport slave (
        output cmd_valid, cmd_code, act_done, is_move, row_full, spawn_blocked,
        input  cmd_ready, act_valid, action, row_addr, lines_cleared, busy, game_over
    );
endinterface

// File: rtl/tetris_move_sequencer.sv
// Tetris move sequencer: arbitrates gravity vs. player commands, issues one action at a time, scans/clears rows.
// Strobe one cycle after acceptance; one outstanding action, commands held off (cmd_ready=0) until back in IDLE.
module tetris_move_sequencer #(
    parameter int WIDTH          = 8,
    parameter int MEM_HEIGHT     = 6,
    parameter int GRAVITY_PERIOD = 16
) (
    input logic                     clk,
    input logic                     rst,
    tetris_move_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_SCAN,
        S_OVER
    } state_t;

    localparam logic [2:0] A_NONE   = 3'd0;
    localparam logic [2:0] A_LEFT   = 3'd1;
    localparam logic [2:0] A_RIGHT  = 3'd2;
    localparam logic [2:0] A_ROTATE = 3'd3;
    localparam logic [2:0] A_DOWN   = 3'd4;
    localparam logic [2:0] A_LOCK   = 3'd5;
    localparam logic [2:0] A_SPAWN  = 3'd6;
    localparam logic [2:0] A_CLEAR  = 3'd7;

    localparam logic [WIDTH-1:0] GRAV_LAST = WIDTH'(GRAVITY_PERIOD - 1);
    localparam logic [WIDTH-1:0] ROW_TOP   = WIDTH'(MEM_HEIGHT - 1);

    state_t           state_q, state_d;
    logic [2:0]       action_q, action_d;
    logic [WIDTH-1:0] row_addr_q, row_addr_d;
    logic [WIDTH-1:0] lines_q, lines_d;
    logic [WIDTH-1:0] grav_cnt_q, grav_cnt_d;
    logic             grav_pend_q, grav_pend_d;
    logic             act_valid_q, act_valid_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             game_over_q, game_over_d;
    logic             grav_wrap;

    always_comb begin
        state_d     = state_q;
        action_d    = action_q;
        row_addr_d  = row_addr_q;
        lines_d     = lines_q;
        grav_cnt_d  = grav_cnt_q;
        grav_pend_d = grav_pend_q;
        grav_wrap   = 1'b0;

        if (state_q != S_OVER) begin
            if (grav_cnt_q == GRAV_LAST) begin
                grav_cnt_d = '0;
                grav_wrap  = 1'b1;
            end else begin
                grav_cnt_d = grav_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (grav_pend_q) begin
                    state_d     = S_ISSUE;
                    action_d    = A_DOWN;
                    grav_pend_d = 1'b0;
                end else if (cmd_ready_q && bus.cmd_valid) begin
                    state_d  = S_ISSUE;
                    action_d = {1'b0, bus.cmd_code} + 3'd1;
                end
            end
            // Out of reset act_valid_q is still low, so ISSUE holds one extra cycle to emit the SPAWN strobe.
            S_ISSUE: begin
                if (act_valid_q) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.act_done) begin
                    case (action_q)
                        A_LEFT, A_RIGHT, A_ROTATE: begin
                            state_d  = S_IDLE;
                            action_d = A_NONE;
                        end
                        A_DOWN: begin
                            if (bus.is_move) begin
                                state_d  = S_IDLE;
                                action_d = A_NONE;
                            end else begin
                                state_d  = S_ISSUE;
                                action_d = A_LOCK;
                            end
                        end
                        A_LOCK: begin
                            state_d    = S_SCAN;
                            action_d   = A_NONE;
                            row_addr_d = ROW_TOP;
                        end
                        // Rows above slid down into this one, so it is scanned again.
                        A_CLEAR: begin
                            state_d  = S_SCAN;
                            action_d = A_NONE;
                            if (lines_q != '1) begin
                                lines_d = lines_q + 1'b1;
                            end
                        end
                        A_SPAWN: begin
                            state_d  = bus.spawn_blocked ? S_OVER : S_IDLE;
                            action_d = A_NONE;
                        end
                        default: begin
                            state_d  = S_IDLE;
                            action_d = A_NONE;
                        end
                    endcase
                end
            end
            S_SCAN: begin
                if (bus.row_full) begin
                    state_d  = S_ISSUE;
                    action_d = A_CLEAR;
                end else if (row_addr_q != '0) begin
                    row_addr_d = row_addr_q - 1'b1;
                end else begin
                    state_d  = S_ISSUE;
                    action_d = A_SPAWN;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d  = S_IDLE;
                action_d = A_NONE;
            end
        endcase

        // A wrap while a tick is already pending collapses into it.
        if (grav_wrap) begin
            grav_pend_d = 1'b1;
        end

        act_valid_d = (state_d == S_ISSUE);
        cmd_ready_d = (state_d == S_IDLE) && !grav_pend_d;
        busy_d      = (state_d != S_IDLE) && (state_d != S_OVER);
        game_over_d = (state_d == S_OVER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ISSUE;
            action_q    <= A_SPAWN;
            row_addr_q  <= '0;
            lines_q     <= '0;
            grav_cnt_q  <= '0;
            grav_pend_q <= 1'b0;
            act_valid_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            action_q    <= action_d;
            row_addr_q  <= row_addr_d;
            lines_q     <= lines_d;
            grav_cnt_q  <= grav_cnt_d;
            grav_pend_q <= grav_pend_d;
            act_valid_q <= act_valid_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            game_over_q <= game_over_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.act_valid     = act_valid_q;
    assign bus.action        = action_q;
    assign bus.row_addr      = row_addr_q;
    assign bus.lines_cleared = lines_q;
    assign bus.busy          = busy_q;
    assign bus.game_over     = game_over_q;

endmodule

// File: doc/tetris_move_sequencer.md
TETRIS_MOVE_SEQUENCER -- requirements
Module: tetris_move_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, coordinate/row-address and counter width.
REQ-002 SHALL have parameter MEM_HEIGHT, default 6, number of playfield rows.
REQ-003 SHALL have parameter GRAVITY_PERIOD, default 16, clock cycles between gravity ticks; legal range >=2.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  player command request.
REQ-007 SHALL have port cmd_code  input  2  0=LEFT, 1=RIGHT, 2=ROTATE, 3=DOWN.
REQ-008 SHALL have port cmd_ready  output  1  command accepted this cycle when high together with cmd_valid.
REQ-009 SHALL have port act_valid  output  1  one-cycle strobe issuing action to tetris datapath.
REQ-010 SHALL have port action  output  3  0=NONE, 1=LEFT, 2=RIGHT, 3=ROTATE, 4=DOWN, 5=LOCK, 6=SPAWN, 7=CLEAR_ROW.
REQ-011 SHALL have port row_addr  output  WIDTH  row under scan/clear.
REQ-012 SHALL have port act_done  input  1  datapath completion pulse for the outstanding action.
REQ-013 SHALL have port is_move  input  1  valid with act_done; 1 = move legal and applied.
REQ-014 SHALL have port row_full  input  1  combinational: row at row_addr fully occupied.
REQ-015 SHALL have port spawn_blocked  input  1  valid with act_done of SPAWN; new piece overlaps stack.
REQ-016 SHALL have port lines_cleared  output  WIDTH  count of cleared rows, saturating at all-ones.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE and OVER.
REQ-018 SHALL have port game_over  output  1  high in OVER.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, SCAN, OVER; ISSUE/WAIT carry the pending action code.
REQ-020 SHALL, in ISSUE, drive act_valid=1 for exactly one cycle with action and row_addr stable, then enter WAIT.
REQ-021 SHALL hold action and row_addr stable in WAIT; act_done outside WAIT SHALL be ignored.
REQ-022 SHALL run a gravity counter 0..GRAVITY_PERIOD-1 in all states except OVER; on wrap set gravity_pending.
REQ-023 SHALL, in IDLE with gravity_pending, go to ISSUE with DOWN and clear gravity_pending; gravity outranks player.
REQ-024 SHALL drive cmd_ready=1 only in IDLE with gravity_pending=0; accepted cmd_code maps to action cmd_code+1 and goes to ISSUE.
REQ-025 SHALL, on act_done for LEFT/RIGHT/ROTATE, or DOWN with is_move=1, return to IDLE.
REQ-026 SHALL, on act_done for DOWN with is_move=0, issue LOCK.
REQ-027 SHALL, on act_done for LOCK, set row_addr=MEM_HEIGHT-1 and enter SCAN.
REQ-028 SHALL, in SCAN, sample row_full once per cycle: full -> issue CLEAR_ROW at row_addr; not full and row_addr>0 -> decrement; not full and row_addr=0 -> issue SPAWN.
REQ-029 SHALL, on act_done for CLEAR_ROW, increment lines_cleared (saturating) and re-enter SCAN at the same row_addr (rows above have shifted down).
REQ-030 SHALL, on act_done for SPAWN, enter OVER if spawn_blocked=1, else IDLE.
REQ-031 SHALL remain in OVER until rst; no act_valid, cmd_ready=0, gravity frozen.
REQ-032 SHALL drop a gravity wrap occurring while gravity_pending is already set (no tick queue).
REQ-033 SHALL ignore is_move for LOCK, SPAWN, CLEAR_ROW.

Reset
REQ-034 SHALL, on rst, asynchronously force: state=ISSUE with action=SPAWN, gravity counter=0, gravity_pending=0, lines_cleared=0, row_addr=0, act_valid=0, cmd_ready=0, game_over=0, busy=1.
REQ-035 SHALL, first rising edge after rst deasserts, emit act_valid=1 action=SPAWN; rst mid-operation abandons any outstanding action.

Verification
REQ-036 Reset, SPAWN done with spawn_blocked=0, cmd_valid=1 cmd_code=0 -> SPAWN strobe cycle 1, then LEFT strobe (action=1) one cycle after acceptance.
REQ-037 cmd_valid held with no commands, GRAVITY_PERIOD=16 -> DOWN strobe every 16 cycles plus ack latency; cmd_ready=0 whenever gravity_pending=1.
REQ-038 DOWN done is_move=0, row_full high only for row 5 once -> LOCK, CLEAR_ROW row_addr=5, rescan row 5, scan 4..0, SPAWN; lines_cleared=1.
REQ-039 SPAWN done with spawn_blocked=1 -> game_over=1, busy=0, no further act_valid for 100 cycles despite cmd_valid=1.
REQ-040 rst pulsed while WAIT for CLEAR_ROW -> all outputs at reset values immediately; lines_cleared=0; next edge SPAWN strobe.
REQ-041 act_done pulsed while IDLE -> no state change, no action issued.
